// File: rtl/rf_fetch_pkg.sv
// Shared defaults and FSM state type for the rf_buffer weight-fetch sequencer.
package rf_fetch_pkg;

   localparam int unsigned DEFAULT_D_WL      = 24;
   localparam int unsigned DEFAULT_UNITS_NUM = 5;
   localparam int unsigned DEFAULT_ADDR_W    = 8;
   localparam int unsigned DEFAULT_DEPTH     = 180;
   localparam int unsigned WORD_W            = DEFAULT_UNITS_NUM * DEFAULT_D_WL;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/rf_fetch_ostage.sv
// Valid/ready output register for fetched weight words; accept strobes a completed handshake.
module rf_fetch_ostage
   import rf_fetch_pkg::*;
#(
   parameter int unsigned DW = WORD_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] d_in,
   input  logic          last_in,
   input  logic          w_ready,
   output logic          w_valid,
   output logic [DW-1:0] w_data,
   output logic          w_last,
   output logic          accept
);

   assign accept = w_valid & w_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_valid <= 1'b0;
         w_data  <= '0;
         w_last  <= 1'b0;
      end else if (load) begin
         w_valid <= 1'b1;
         w_data  <= d_in;
         w_last  <= last_in;
      end else if (accept) begin
         w_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/rf_weight_fetch.sv
// Walks a contiguous rf_buffer address range and streams each word over valid/ready.
// Optional RF_FETCH_WRAP_EN: address counter wraps DEPTH-1 -> 0 instead of rejecting overruns.
module rf_weight_fetch
   import rf_fetch_pkg::*;
#(
   parameter int unsigned D_WL      = DEFAULT_D_WL,
   parameter int unsigned UNITS_NUM = DEFAULT_UNITS_NUM,
   parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
   parameter int unsigned DEPTH     = DEFAULT_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [ADDR_W-1:0]         base_addr,
   input  logic [ADDR_W-1:0]         len,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [ADDR_W-1:0]         rf_addr,
   input  logic [UNITS_NUM*D_WL-1:0] rf_w_i,
   output logic                      w_valid,
   input  logic                      w_ready,
   output logic [UNITS_NUM*D_WL-1:0] w_data,
   output logic                      w_last
);

   localparam int unsigned       WW      = UNITS_NUM * D_WL;
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);

   fetch_state_e      state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] remaining;
   logic [ADDR_W-1:0] addr_nxt;
   logic              load;
   logic              accept;
   logic              base_ok;
   logic              range_ok;

   assign rf_addr = addr;
   assign busy    = (state != IDLE);
   assign load    = (state == RUN) && (!w_valid || w_ready);
   assign base_ok = ({1'b0, base_addr} < DEPTH_X);

`ifdef RF_FETCH_WRAP_EN
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
   assign addr_nxt = (addr == LAST_A) ? '0 : addr + 1'b1;
   assign range_ok = base_ok && ({1'b0, len} <= DEPTH_X);
`else
   assign addr_nxt = addr + 1'b1;
   assign range_ok = base_ok && (({1'b0, base_addr} + {1'b0, len}) <= DEPTH_X);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (!range_ok) begin
                     err <= 1'b1;
                  end else if (len == '0) begin
                     done <= 1'b1;
                  end else begin
                     addr      <= base_addr;
                     remaining <= len;
                     state     <= RUN;
                  end
               end
            end
            RUN: begin
               // the word tagged last is loaded on the same edge we leave RUN
               if (load) begin
                  addr      <= addr_nxt;
                  remaining <= remaining - 1'b1;
                  if (remaining == ADDR_W'(1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (accept && w_last) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   rf_fetch_ostage #(
      .DW (WW)
   ) u_ostage (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .d_in    (rf_w_i),
      .last_in (remaining == ADDR_W'(1)),
      .w_ready (w_ready),
      .w_valid (w_valid),
      .w_data  (w_data),
      .w_last  (w_last),
      .accept  (accept)
   );

endmodule

// File: doc/rf_weight_fetch.md
# rf_weight_fetch

Weight-fetch sequencer on the read side of the LSTM weight ROM (`rf_buffer`).
- On a `start` command it walks a contiguous address range and drives `rf_addr`.
- It captures the combinational `UNITS_NUM*D_WL`-bit word returned on `rf_w_i` and streams it to the MAC array over a valid/ready interface, one word per cycle at full throughput.
- It sits between the layer controller (command side) and the per-unit MAC lanes (data side).

## Interface
- `D_WL`, 24, weight word length per unit (bits).
- `UNITS_NUM`, 5, units packed per ROM word.
- `ADDR_W`, 8, ROM address width.
- `DEPTH`, 180, number of valid ROM words.
- Clocking and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  command strobe, sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address, sampled with `start`.
- `len`  in  ADDR_W  number of words to fetch, sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the final output handshake.
- `err`  out  1  one-cycle pulse when a command is rejected.
- `rf_addr`  out  ADDR_W  address driven to the ROM.
- `rf_w_i`  in  UNITS_NUM*D_WL  ROM read data (combinational from `rf_addr`).
- `w_valid`  out  1  output word valid.
- `w_ready`  in  1  consumer ready.
- `w_data`  out  UNITS_NUM*D_WL  output word; unit k occupies bits [k*D_WL +: D_WL].
- `w_last`  out  1  qualifies the final word of a command.

## Operation
- FSM states:
  - IDLE: waits for a command.
  - RUN: addresses are still to be issued.
  - DRAIN: all addresses issued; waiting for the last word to be accepted.
- Accepted `start` in IDLE:
  - If `len==0`: no data is produced; `done` pulses next cycle; the FSM stays in IDLE.
  - If `len!=0` and the range is legal: the counter loads `base_addr`, `remaining` loads `len`, and the FSM goes to RUN.
- `start` while not IDLE is ignored.
- Load condition: `load = (state==RUN) && (!w_valid || w_ready)`.
- On `load`:
  - `w_data <= rf_w_i` and `w_valid <= 1`.
  - `w_last <= (remaining==1)`.
  - Address counter increments; `remaining` decrements.
  - When `remaining` reaches 1, RUN goes to DRAIN.
- Output register is cleared (`w_valid <= 0`) when `w_valid && w_ready && !load`.
- DRAIN goes to IDLE on the handshake where `w_last==1`; `done` pulses the following cycle.
- `rf_addr` always equals the address counter. Its value in IDLE is don't-care; it is held at the last value.
- Output stability: while `w_valid && !w_ready`, `w_data` and `w_last` are held stable.
- `busy = (state != IDLE)`.
- Reset: every output is 0, including `rf_addr`, `w_data`, `busy`, `done`, `err`, `w_valid` and `w_last`. The FSM goes to IDLE and counters clear.
- Reset mid-command: the command is abandoned; no `done` and no `err` are produced.

## Timing
- `start` sampled at edge 0. `rf_addr=base_addr` during cycle 1. `w_valid` rises at edge 1 (visible cycle 1→2 boundary), so first-word latency is 2 cycles from `start`.
- With `w_ready` held high: one word per cycle; the last word is visible in cycle `len+1`; `done` pulses in cycle `len+2`.
- Backpressure: deasserting `w_ready` stalls both the address counter and the output register in the same cycle. No word is lost or duplicated.

## Configuration
- Macro: `RF_FETCH_WRAP_EN`.
- Defined: the address counter wraps from `DEPTH-1` to 0. Any `base_addr<DEPTH` with `len<=DEPTH` is legal.
- Undefined: a command with `base_addr+len>DEPTH` or `base_addr>=DEPTH` is rejected. `err` pulses the next cycle and the FSM stays in IDLE.
- Defined, out-of-range `base_addr` (`base_addr>=DEPTH`): still rejected with `err`.

## Structure
- Package `rf_fetch_pkg` holds:
  - default `D_WL`, `UNITS_NUM`, `ADDR_W`, `DEPTH` constants;
  - the FSM state enum (IDLE, RUN, DRAIN);
  - the `WORD_W = UNITS_NUM*D_WL` localparam.
- One sub-module: `rf_fetch_ostage`, the valid/ready output register holding `w_data`/`w_last`. It takes `load` and exposes the `accept = w_valid & w_ready` strobe back to the FSM.
- `rf_buffer` is instantiated by the parent, not inside this block.

## Test plan
- Basic: `base_addr=0`, `len=1`, `w_ready=1`.
  - `w_data=120'h000045002207000cefffe393000b71` with `w_last=1` in cycle 2.
  - `done` pulses in cycle 3.
- Streaming: `base_addr=176`, `len=4`, `w_ready=1` → four consecutive words for addresses 176..179, `w_last` only on the 4th, `busy` high for 5 cycles.
- Backpressure: `len=8`, `w_ready` toggling 1,0,0,1,… → every address appears exactly once, in order, and `w_data` is stable across stalled cycles.
- Range, `base_addr=178`, `len=3`:
  - without `RF_FETCH_WRAP_EN`: `err` pulse, no `w_valid`, `busy` stays 0;
  - with the macro: words for addresses 178, 179, 0.
- Zero length and ignored start:
  - `len=0` → `done` pulse in cycle 1, no `w_valid`;
  - a second `start` issued mid-command → ignored, the first command completes unchanged.
- Reset mid-command: `rst_n=0` for 1 cycle during word 3 of 8 → all outputs 0 next cycle, no `done`; a subsequent command runs normally.
